// File: rtl/alien_rom_arbiter.sv
// Round-robin arbiter sharing one 8x11 RGB444 alien sprite ROM among NUM_REQ pixel requesters.
// Latency: grant is combinational in the request cycle; tagged colour returns 2 cycles later.
// Backpressure: an ungranted requester holds req/address; one grant and one return per cycle, no bubbles.
// Optional: define ALIEN_ARB_TRANSPARENCY_EN to add rd_opaque (returned colour is not background white).
module alien_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [3*NUM_REQ-1:0] req_row,
  input  logic [4*NUM_REQ-1:0] req_col,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [2:0]           rom_row,
  output logic [3:0]           rom_col,
  input  logic [11:0]          rom_data,
  output logic                 rd_valid,
  output logic [ID_W-1:0]      rd_id,
  output logic [11:0]          rd_data
`ifdef ALIEN_ARB_TRANSPARENCY_EN
  ,
  output logic                 rd_opaque
`endif
);

  localparam logic [ID_W:0]   NUM_W   = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] win_id;
  logic            win_vld;
  logic            grant;
  logic [ID_W:0]   sel_sum;
  logic [ID_W-1:0] sel_idx;
  logic [2:0]      last_row;
  logic [3:0]      last_col;
  logic            s1_vld;
  logic [ID_W-1:0] s1_id;

  // Scan requesters starting at ptr, wrapping, and keep the first one asserting req.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    sel_sum = '0;
    sel_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (sel_sum >= NUM_W) sel_sum = sel_sum - NUM_W;
      sel_idx = sel_sum[ID_W-1:0];
      if (!win_vld && req[sel_idx]) begin
        win_vld = 1'b1;
        win_id  = sel_idx;
      end
    end
  end

  // Reset suppresses the grant even though the selection logic is combinational.
  assign grant = win_vld & ~reset;

  // One-hot grant and ROM address mux; idle cycles replay the last granted address.
  always_comb begin
    gnt     = '0;
    rom_row = last_row;
    rom_col = last_col;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant && (win_id == ID_W'(i))) begin
        gnt[i]  = 1'b1;
        rom_row = req_row[3*i +: 3];
        rom_col = req_col[4*i +: 4];
      end
    end
  end

  // Advance the priority pointer past the winner and remember the granted address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr      <= '0;
      last_row <= '0;
      last_col <= '0;
    end else if (grant) begin
      ptr      <= (win_id == LAST_ID) ? '0 : win_id + 1'b1;
      last_row <= rom_row;
      last_col <= rom_col;
    end
  end

  // Stage 1: tag travelling alongside the ROM's registered address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld <= 1'b0;
      s1_id  <= '0;
    end else begin
      s1_vld <= grant;
      s1_id  <= win_id;
    end
  end

  // Stage 2: join the ROM colour with its tag; column 11..15 zeros pass through untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_id    <= '0;
      rd_data  <= 12'h000;
    end else begin
      rd_valid <= s1_vld;
      rd_id    <= s1_id;
      rd_data  <= rom_data;
    end
  end

`ifdef ALIEN_ARB_TRANSPARENCY_EN
  // Opacity flag registered with stage 2 so it lines up with rd_valid; white is background.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_opaque <= 1'b0;
    else       rd_opaque <= (rom_data != 12'hFFF);
  end
`endif

endmodule

// File: doc/alien_rom_arbiter.md
# alien_rom_arbiter

Round-robin arbiter that shares one 8-row × 11-column, 12-bit-colour alien sprite ROM among several pixel requesters, such as per-row alien renderers or the explosion overlay. Each cycle it picks at most one requester and drives its row/col to the ROM. It tracks the ROM's one-cycle registered-address latency and returns the colour word tagged with the requester ID. It sits between the VGA pixel-generation logic and the sprite ROM instance.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- ID_W, 2: requester ID width, equal to clog2(NUM_REQ), minimum 1.

- clk  in  1  pixel clock; also clocks the ROM.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; held until granted.
- req_row  in  3*NUM_REQ  sprite row per requester; requester i uses bits [3i+2:3i].
- req_col  in  4*NUM_REQ  sprite column per requester; requester i uses bits [4i+3:4i].
- gnt  out  NUM_REQ  one-hot grant, combinational in the request cycle.
- rom_row  out  3  row address to the ROM.
- rom_col  out  4  column address to the ROM.
- rom_data  in  12  ROM colour output, valid one cycle after the address.
- rd_valid  out  1  return data valid.
- rd_id  out  ID_W  requester index for the return.
- rd_data  out  12  returned RGB444 colour.
- rd_opaque  out  1  pixel is not background. Present only with ALIEN_ARB_TRANSPARENCY_EN.

## Operation
- Priority pointer ptr, range 0..NUM_REQ-1; reset value 0.
- Winner selection: scan from ptr upward, modulo NUM_REQ. The first i with req[i]=1 wins.
  - gnt[i]=1 for the winner.
  - rom_row/rom_col take req_row/req_col of requester i.
  - On the clock edge, ptr <= (i+1) mod NUM_REQ.
- No request: gnt=0, ptr unchanged. rom_row/rom_col hold the last granted address from an internal register, which is 0 after reset.
- Requester protocol:
  - The requester samples gnt in the same cycle.
  - On gnt it may drop req or present a new address next cycle.
  - Without gnt it must hold req and its address stable.
- Pipeline, two registered stages:
  - S1 captures {valid, id} of the grant.
  - S2 captures rom_data together with S1's {valid, id}.
  - rd_valid, rd_id and rd_data come from S2.
- Columns 11..15 are granted normally. The ROM returns 12'h000 for them and rd_data passes it through unmodified.
- A requester may hold req continuously. Round-robin still guarantees that every active requester is granted within NUM_REQ cycles.

## Timing
- Grant in cycle N. rd_valid=1 with rd_id/rd_data in cycle N+2, so latency is 2 cycles.
- Throughput is one grant and one return per cycle. Back-to-back grants produce back-to-back rd_valid with no bubble.
- Reset values: gnt=0 (reset forces no grant), rom_row=0, rom_col=0, rd_valid=0, rd_id=0, rd_data=12'h000, rd_opaque=0.
- Reset asserted mid-operation:
  - S1/S2 valid bits clear asynchronously.
  - In-flight returns are discarded, never delivered.
  - ptr returns to 0.
- First grant after reset release: earliest in the first cycle reset is low. Selection starts from requester 0.
- Simultaneous req on all inputs with ptr=k: grants are k, k+1, …, wrapping modulo NUM_REQ.
- A request that is dropped before being granted is never answered.

## Configuration
- ALIEN_ARB_TRANSPARENCY_EN
  - Defined: rd_opaque port exists. rd_opaque = (rd_data != 12'hFFF), registered with S2 and aligned with rd_valid. White 12'hFFF is the sprite background colour.
  - Undefined: the port is absent. Downstream logic treats every returned pixel as opaque.

## Test plan
- Reset, then req=4'b0001, row=0, col=2 → gnt=0001 in cycle 0; rd_valid=1, rd_id=0, rd_data=12'h6D1 in cycle 2; with the macro defined, rd_opaque=1.
- req=4'b1111 held for 8 cycles with distinct addresses → grant order 0,1,2,3,0,1,2,3; rd_id sequence matches, offset by 2 cycles; no gaps in rd_valid.
- Requester 0 is granted (ptr=1), then req=4'b0101 → grant goes to 2, then 0.
- Requester 1 requests row=7, col=12 → rd_data=12'h000 at latency 2.
- Requester 3 requests row=0, col=0 → rd_data=12'hFFF; with the macro, rd_opaque=0.
- Continuous traffic, reset pulsed in cycle 5 → rd_valid=0 immediately and stays 0 until 2 cycles after the first post-reset grant; first grant goes to the lowest active index.
